// File: rtl/multimode_wave_gen_if.sv
// Control and waveform signal bundle for multimode_wave_gen.
// The master drives enable and configuration; the slave returns the waveform and its strobes.
interface multimode_wave_gen_if #(
   parameter int WIDTH = 16
);
   logic             enable;
   logic [1:0]       mode_in;
   logic [WIDTH-1:0] max_in;
   logic [WIDTH-1:0] step_in;
   logic             cfg_load;
   logic             cfg_ack;
   logic [WIDTH-1:0] count;
   logic             direction;
   logic             period_tick;

   modport master (
      output enable, mode_in, max_in, step_in, cfg_load,
      input  cfg_ack, count, direction, period_tick
   );

   modport slave (
      input  enable, mode_in, max_in, step_in, cfg_load,
      output cfg_ack, count, direction, period_tick
   );
endinterface

// File: rtl/multimode_wave_gen.sv
// Triangle / saw-up / saw-down / square code generator with run-time peak and step.
// New settings wait in a shadow register and take effect only at a period boundary.
module multimode_wave_gen #(
   parameter int         WIDTH        = 16,
   parameter int         DEFAULT_MAX  = 15151,
   parameter logic [1:0] DEFAULT_MODE = 2'b00
) (
   input  logic                 clk,
   input  logic                 reset,
   multimode_wave_gen_if.slave  bus
);
   localparam logic [1:0] MODE_TRI = 2'b00;
   localparam logic [1:0] MODE_UP  = 2'b01;
   localparam logic [1:0] MODE_DN  = 2'b10;
   localparam logic [1:0] MODE_SQ  = 2'b11;

   typedef enum logic {RISING = 1'b0, FALLING = 1'b1} dir_t;

   logic [1:0]       r_mode, r_sh_mode;
   logic [WIDTH-1:0] r_max, r_sh_max, r_step, r_sh_step;
   logic             r_pending;
   logic [WIDTH-1:0] r_acc;
   dir_t             r_dir;
   logic [WIDTH-1:0] r_count;
   logic             r_direction, r_tick, r_ack;

   logic [WIDTH-1:0] w_step_eff;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_acc_nat;
   dir_t             w_dir_nat;
   logic             w_wrap, w_apply;
   logic [1:0]       w_mode_next, w_sh_mode_next;
   logic [WIDTH-1:0] w_max_next, w_step_next, w_sh_max_next, w_sh_step_next;
   logic             w_pending_next;
   logic [WIDTH-1:0] w_acc_next, w_count_next;
   dir_t             w_dir_next;
   logic             w_direction_next, w_tick_next, w_ack_next;

   // Free-running next state of the current waveform, ignoring enable and reconfiguration.
   always_comb begin
      w_step_eff = (r_step == '0) ? WIDTH'(1) : r_step;
      w_sum      = {1'b0, r_acc} + {1'b0, w_step_eff};
      w_acc_nat  = r_acc;
      w_dir_nat  = r_dir;
      w_wrap     = 1'b0;
      if (r_max == '0) begin
         w_acc_nat = '0;
         w_dir_nat = RISING;
         w_wrap    = 1'b1;
      end else begin
         case (r_mode)
            MODE_UP: begin
               if (w_sum > {1'b0, r_max}) begin
                  w_acc_nat = '0;
                  w_wrap    = 1'b1;
               end else begin
                  w_acc_nat = w_sum[WIDTH-1:0];
               end
            end
            MODE_DN: begin
               if (r_acc < w_step_eff) begin
                  w_acc_nat = r_max;
                  w_wrap    = 1'b1;
               end else begin
                  w_acc_nat = r_acc - w_step_eff;
               end
            end
            default: begin
               if (r_dir == RISING) begin
                  if (w_sum >= {1'b0, r_max}) begin
                     w_acc_nat = r_max;
                     w_dir_nat = FALLING;
                  end else begin
                     w_acc_nat = w_sum[WIDTH-1:0];
                  end
               end else if (r_acc <= w_step_eff) begin
                  w_acc_nat = '0;
                  w_dir_nat = RISING;
                  w_wrap    = 1'b1;
               end else begin
                  w_acc_nat = r_acc - w_step_eff;
               end
            end
         endcase
      end
   end

   always_comb begin
      w_apply        = r_pending && (!bus.enable || w_wrap);
      w_mode_next    = r_mode;
      w_max_next     = r_max;
      w_step_next    = r_step;
      w_acc_next     = r_acc;
      w_dir_next     = r_dir;
      w_tick_next    = 1'b0;
      w_ack_next     = 1'b0;
      w_sh_mode_next = r_sh_mode;
      w_sh_max_next  = r_sh_max;
      w_sh_step_next = r_sh_step;
      w_pending_next = r_pending;

      if (w_apply) begin
         w_mode_next = r_sh_mode;
         w_max_next  = r_sh_max;
         w_step_next = r_sh_step;
         w_acc_next  = (r_sh_mode == MODE_DN) ? r_sh_max : '0;
         w_dir_next  = RISING;
         w_ack_next  = 1'b1;
         w_tick_next = bus.enable;
         w_pending_next = 1'b0;
      end else if (bus.enable) begin
         w_acc_next  = w_acc_nat;
         w_dir_next  = w_dir_nat;
         w_tick_next = w_wrap;
      end

      // A load coinciding with an apply is kept for the following boundary.
      if (bus.cfg_load) begin
         w_sh_mode_next = bus.mode_in;
         w_sh_max_next  = bus.max_in;
         w_sh_step_next = bus.step_in;
         w_pending_next = 1'b1;
      end

      if (w_mode_next == MODE_SQ)
         w_count_next = (w_dir_next == FALLING) ? w_max_next : '0;
      else
         w_count_next = w_acc_next;
      w_direction_next = ((w_mode_next == MODE_TRI) || (w_mode_next == MODE_SQ))
                         && (w_dir_next == FALLING);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode      <= DEFAULT_MODE;
         r_max       <= WIDTH'(DEFAULT_MAX);
         r_step      <= WIDTH'(1);
         r_sh_mode   <= DEFAULT_MODE;
         r_sh_max    <= WIDTH'(DEFAULT_MAX);
         r_sh_step   <= WIDTH'(1);
         r_pending   <= 1'b0;
         r_acc       <= '0;
         r_dir       <= RISING;
         r_count     <= '0;
         r_direction <= 1'b0;
         r_tick      <= 1'b0;
         r_ack       <= 1'b0;
      end else begin
         r_mode      <= w_mode_next;
         r_max       <= w_max_next;
         r_step      <= w_step_next;
         r_sh_mode   <= w_sh_mode_next;
         r_sh_max    <= w_sh_max_next;
         r_sh_step   <= w_sh_step_next;
         r_pending   <= w_pending_next;
         r_acc       <= w_acc_next;
         r_dir       <= w_dir_next;
         r_count     <= w_count_next;
         r_direction <= w_direction_next;
         r_tick      <= w_tick_next;
         r_ack       <= w_ack_next;
      end
   end

   assign bus.count       = r_count;
   assign bus.direction   = r_direction;
   assign bus.period_tick = r_tick;
   assign bus.cfg_ack     = r_ack;
endmodule

// File: tb/tb_multimode_wave_gen.sv
// Bench for multimode_wave_gen: fixed vector table, reset corner sequence, and
// random traffic compared with a phase-index model of each waveform.
module tb_multimode_wave_gen;
   localparam int WIDTH = 16;
   localparam int DMAX  = 15151;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multimode_wave_gen_if #(.WIDTH(WIDTH)) bus ();

   multimode_wave_gen #(.WIDTH(WIDTH), .DEFAULT_MAX(DMAX), .DEFAULT_MODE(2'b00)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit en;
      bit ld;
      int md;
      int mx;
      int st;
      int cnt;
      bit dr;
      bit tk;
      bit ak;
   } vec_t;

   vec_t vec_q[$];
   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: active config, phase within period, shadow config.
   int m_md, m_mx, m_st, m_ph;
   int s_md, s_mx, s_st;
   bit m_pend;
   int e_cnt;
   bit e_dr, e_tk, e_ak;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input bit en, input bit ld, input int md, input int mx, input int st,
                      input int cnt, input bit dr, input bit tk, input bit ak);
      vec_t v;
      v.en = en; v.ld = ld; v.md = md; v.mx = mx; v.st = st;
      v.cnt = cnt; v.dr = dr; v.tk = tk; v.ak = ak;
      vec_q.push_back(v);
   endtask

   task automatic drive(input bit en, input bit ld, input int md, input int mx, input int st);
      bus.enable   = en;
      bus.cfg_load = ld;
      bus.mode_in  = 2'(md);
      bus.max_in   = WIDTH'(mx);
      bus.step_in  = WIDTH'(st);
   endtask

   task automatic check_all(input string tag, input int cnt, input bit dr, input bit tk, input bit ak);
      check({tag, ".count"}, int'(bus.count), cnt);
      check({tag, ".direction"}, int'(bus.direction), int'(dr));
      check({tag, ".period_tick"}, int'(bus.period_tick), int'(tk));
      check({tag, ".cfg_ack"}, int'(bus.cfg_ack), int'(ak));
   endtask

   function automatic int f_period(input int md, input int mx, input int st);
      if (mx == 0) return 1;
      if (md == 1 || md == 2) return mx / st + 1;
      return 2 * ((mx + st - 1) / st);
   endfunction

   // Waveform value at phase p: triangle rises for n phases then falls for n phases.
   task automatic f_value(input int md, input int mx, input int st, input int p,
                          output int cnt, output bit dr);
      int n;
      cnt = 0;
      dr  = 1'b0;
      if (mx == 0) return;
      if (md == 1) cnt = p * st;
      else if (md == 2) cnt = mx - p * st;
      else begin
         n  = (mx + st - 1) / st;
         dr = (p >= n);
         cnt = dr ? (mx - (p - n) * st) : p * st;
         if (md == 3) cnt = dr ? mx : 0;
      end
   endtask

   task automatic model_reset();
      m_md = 0; m_mx = DMAX; m_st = 1; m_ph = 0;
      s_md = 0; s_mx = DMAX; s_st = 1; m_pend = 1'b0;
      e_cnt = 0; e_dr = 1'b0; e_tk = 1'b0; e_ak = 1'b0;
   endtask

   task automatic model_edge(input bit en, input bit ld, input int md, input int mx, input int st);
      bit wrap, apply;
      wrap  = en && (m_ph + 1 == f_period(m_md, m_mx, m_st));
      apply = m_pend && (!en || wrap);
      e_ak = apply;
      e_tk = en && wrap;
      if (apply) begin
         m_md = s_md; m_mx = s_mx; m_st = (s_st == 0) ? 1 : s_st; m_ph = 0;
         m_pend = 1'b0;
      end else if (en) begin
         m_ph = wrap ? 0 : m_ph + 1;
      end
      if (ld) begin
         s_md = md; s_mx = mx; s_st = st; m_pend = 1'b1;
      end
      f_value(m_md, m_mx, m_st, m_ph, e_cnt, e_dr);
   endtask

   initial begin
      vec_t v;
      int md, mx, st;
      bit en, ld;

      // Triangle max 4 step 1, then hold with a queued max 10 step 3 load.
      add(0,1,0,4,1,  0,0,0,0); add(0,0,0,0,0, 0,0,0,1);
      add(1,0,0,0,0,  1,0,0,0); add(1,0,0,0,0, 2,0,0,0); add(1,0,0,0,0, 3,0,0,0);
      add(1,0,0,0,0,  4,1,0,0); add(1,0,0,0,0, 3,1,0,0); add(1,0,0,0,0, 2,1,0,0);
      add(1,0,0,0,0,  1,1,0,0); add(1,0,0,0,0, 0,0,1,0); add(1,0,0,0,0, 1,0,0,0);
      add(0,1,0,10,3, 1,0,0,0); add(0,0,0,0,0, 0,0,0,1);
      add(1,0,0,0,0,  3,0,0,0); add(1,0,0,0,0, 6,0,0,0); add(1,0,0,0,0, 9,0,0,0);
      add(1,0,0,0,0, 10,1,0,0); add(1,0,0,0,0, 7,1,0,0); add(1,0,0,0,0, 4,1,0,0);
      add(1,0,0,0,0,  1,1,0,0); add(1,0,0,0,0, 0,0,1,0);
      // Saw up then saw down, max 4 step 1.
      add(0,1,1,4,1,  0,0,0,0); add(0,0,0,0,0, 0,0,0,1);
      add(1,0,0,0,0,  1,0,0,0); add(1,0,0,0,0, 2,0,0,0); add(1,0,0,0,0, 3,0,0,0);
      add(1,0,0,0,0,  4,0,0,0); add(1,0,0,0,0, 0,0,1,0);
      add(0,1,2,4,1,  0,0,0,0); add(0,0,0,0,0, 4,0,0,1);
      add(1,0,0,0,0,  3,0,0,0); add(1,0,0,0,0, 2,0,0,0); add(1,0,0,0,0, 1,0,0,0);
      add(1,0,0,0,0,  0,0,0,0); add(1,0,0,0,0, 4,0,1,0);
      // Square max 4 with step_in 0 acting as step 1.
      add(0,1,3,4,0,  4,0,0,0); add(0,0,0,0,0, 0,0,0,1);
      add(1,0,0,0,0,  0,0,0,0); add(1,0,0,0,0, 0,0,0,0); add(1,0,0,0,0, 0,0,0,0);
      add(1,0,0,0,0,  4,1,0,0); add(1,0,0,0,0, 4,1,0,0); add(1,0,0,0,0, 4,1,0,0);
      add(1,0,0,0,0,  4,1,0,0); add(1,0,0,0,0, 0,0,1,0);
      // Mid-period load of triangle max 8: square finishes, ack lands with the tick.
      add(1,1,0,8,1,  0,0,0,0); add(1,0,0,0,0, 0,0,0,0); add(1,0,0,0,0, 0,0,0,0);
      add(1,0,0,0,0,  4,1,0,0); add(1,0,0,0,0, 4,1,0,0); add(1,0,0,0,0, 4,1,0,0);
      add(1,0,0,0,0,  4,1,0,0); add(1,0,0,0,0, 0,0,1,1);
      add(1,0,0,0,0,  1,0,0,0); add(1,0,0,0,0, 2,0,0,0);
      // max 0: tick on every enabled cycle, saw up and triangle.
      add(0,1,1,0,1,  2,0,0,0); add(0,0,0,0,0, 0,0,0,1);
      add(1,0,0,0,0,  0,0,1,0); add(1,0,0,0,0, 0,0,1,0); add(1,0,0,0,0, 0,0,1,0);
      add(0,1,0,0,1,  0,0,0,0); add(0,0,0,0,0, 0,0,0,1);
      add(1,0,0,0,0,  0,0,1,0); add(1,0,0,0,0, 0,0,1,0);

      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 0, 0, 0);
      reset = 1'b0;

      for (int i = 0; i < vec_q.size(); i++) begin
         v = vec_q[i];
         drive(v.en, v.ld, v.md, v.mx, v.st);
         @(posedge clk);
         #1;
         $display("row %0d: en=%0d ld=%0d count=%0d dir=%0d tick=%0d ack=%0d", i, v.en, v.ld,
                  bus.count, bus.direction, bus.period_tick, bus.cfg_ack);
         check_all($sformatf("row%0d", i), v.cnt, v.dr, v.tk, v.ak);
      end

      // Reset in the middle of a ramp with a load still pending.
      drive(0, 1, 0, 10, 1); @(posedge clk); #1;
      drive(0, 0, 0, 0, 0);  @(posedge clk); #1;
      for (int i = 1; i <= 6; i++) begin
         drive(1, 0, 0, 0, 0); @(posedge clk); #1;
      end
      drive(1, 1, 2, 3, 1); @(posedge clk); #1;
      check("ramp.count7", int'(bus.count), 7);
      drive(0, 0, 0, 0, 0);
      #2 reset = 1'b1;
      #1;
      $display("async reset: count=%0d dir=%0d", bus.count, bus.direction);
      check_all("async_reset", 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check_all($sformatf("post_reset_idle%0d", i), 0, 0, 0, 0);
      end
      for (int i = 1; i <= 3; i++) begin
         drive(1, 0, 0, 0, 0); @(posedge clk); #1;
         check_all($sformatf("post_reset_run%0d", i), i, 0, 0, 0);
      end

      // Random traffic against the phase model.
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         en = ($urandom_range(0, 99) < 85);
         ld = ($urandom_range(0, 99) < 6);
         md = int'($urandom_range(0, 3));
         mx = int'($urandom_range(0, 20));
         st = int'($urandom_range(0, 6));
         if (cyc == 0) begin en = 1'b0; ld = 1'b1; end
         if (cyc == 1) begin en = 1'b0; ld = 1'b0; end
         drive(en, ld, md, mx, st);
         @(posedge clk);
         model_edge(en, ld, md, mx, st);
         #1;
         if (ld) $display("cyc %0d: cfg_load mode=%0d max=%0d step=%0d en=%0d", cyc, md, mx, st, en);
         check_all($sformatf("rand%0d", cyc), e_cnt, e_dr, e_tk, e_ak);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
